// File: rtl/board_io_frontend_pkg.sv
// ---------------------------------------------------------------------------
// board_io_frontend_pkg
//   Shared constants and width helpers for the board input front end.
//   - DEFAULT_N_IN : channel count used by board tops unless overridden.
//   - cnt_width()  : debounce counter width for a given stable-cycle count.
//   - hold_width() : reset-stretch counter width for a given hold length.
// ---------------------------------------------------------------------------
package board_io_frontend_pkg;

   localparam int unsigned DEFAULT_N_IN = 8;

   // The counter must be able to hold DEBOUNCE_CYC-1 without wrapping.
   function automatic int unsigned cnt_width(input int unsigned debounce_cyc);
      return $clog2(debounce_cyc + 1);
   endfunction

   // The hold counter saturates at RST_HOLD, so it must represent that value.
   function automatic int unsigned hold_width(input int unsigned rst_hold);
      return $clog2(rst_hold + 1);
   endfunction

endpackage

// File: rtl/board_io_frontend_debounce_ch.sv
// ---------------------------------------------------------------------------
// board_io_frontend_debounce_ch
//   One conditioned input channel: synchroniser chain, debounce counter,
//   accepted level and registered one-cycle rise/fall pulses.
// Ports
//   clk     in  system clock
//   resetn  in  asynchronous active-low reset
//   raw_i   in  asynchronous pin input
//   level_o out debounced level
//   rise_o  out one-cycle pulse, the cycle after level_o goes 0->1
//   fall_o  out one-cycle pulse, the cycle after level_o goes 1->0
// ---------------------------------------------------------------------------
module board_io_frontend_debounce_ch
   import board_io_frontend_pkg::*;
#(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_CYC = 1000,
   parameter logic        INIT_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned           CNT_W    = cnt_width(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   level_prev_q;
   logic                   rise_q, fall_q;

   assign sync_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync_s == level_q) begin
         // Agreement (including a bounce back) restarts the stability count.
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync_s;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q       <= {SYNC_STAGES{INIT_LEVEL}};
         cnt_q        <= '0;
         level_q      <= INIT_LEVEL;
         level_prev_q <= INIT_LEVEL;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
      end else begin
         // Pure flop chain: no logic between synchroniser stages.
         sync_q       <= {sync_q[SYNC_STAGES-2:0], raw_i};
         cnt_q        <= cnt_d;
         level_q      <= level_d;
         // Comparing against the previous level makes the pulse land one
         // cycle after level_o changes.
         level_prev_q <= level_q;
         rise_q       <= level_q & ~level_prev_q;
         fall_q       <= ~level_q & level_prev_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_frontend.sv
// ---------------------------------------------------------------------------
// board_io_frontend
//   Board input conditioning between FPGA pins and the SoC: per-channel
//   synchronise/debounce, edge detection with sticky maskable pending bits
//   driving an active-low irq_n, and a stretched SoC reset from a pushbutton.
// Ports
//   clk        in   system clock
//   resetn     in   asynchronous active-low reset
//   raw_in     in   [N_IN] asynchronous pin inputs
//   rst_btn    in   asynchronous reset pushbutton, active-high
//   rise_en    in   [N_IN] rising edge sets pending
//   fall_en    in   [N_IN] falling edge sets pending
//   irq_mask   in   [N_IN] 1 = pending bit may drive irq_n
//   irq_clr    in   [N_IN] one-cycle clear strobe for pending
//   level_out  out  [N_IN] debounced level
//   rise_pulse out  [N_IN] one-cycle pulse after level_out 0->1
//   fall_pulse out  [N_IN] one-cycle pulse after level_out 1->0
//   pending    out  [N_IN] sticky interrupt-pending bits
//   irq_n      out  active-low interrupt, registered
//   sys_resetn out  stretched active-low reset for the SoC
// ---------------------------------------------------------------------------
module board_io_frontend
   import board_io_frontend_pkg::*;
#(
   parameter int unsigned N_IN         = DEFAULT_N_IN,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned DEBOUNCE_CYC = 1000,
   parameter logic        INIT_LEVEL   = 1'b0,
   parameter int unsigned RST_HOLD     = 16
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [N_IN-1:0] raw_in,
   input  logic            rst_btn,
   input  logic [N_IN-1:0] rise_en,
   input  logic [N_IN-1:0] fall_en,
   input  logic [N_IN-1:0] irq_mask,
   input  logic [N_IN-1:0] irq_clr,
   output logic [N_IN-1:0] level_out,
   output logic [N_IN-1:0] rise_pulse,
   output logic [N_IN-1:0] fall_pulse,
   output logic [N_IN-1:0] pending,
   output logic            irq_n,
   output logic            sys_resetn
);

   localparam int unsigned      HOLD_W   = hold_width(RST_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(RST_HOLD);

   // ---------------- per-channel conditioning ----------------
   genvar gi;
   generate
      for (gi = 0; gi < N_IN; gi++) begin : g_ch
         board_io_frontend_debounce_ch #(
            .SYNC_STAGES  (SYNC_STAGES),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .INIT_LEVEL   (INIT_LEVEL)
         ) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .raw_i   (raw_in[gi]),
            .level_o (level_out[gi]),
            .rise_o  (rise_pulse[gi]),
            .fall_o  (fall_pulse[gi])
         );
      end
   endgenerate

   // ---------------- pending / irq ----------------
   logic [N_IN-1:0] pend_q, pend_d;
   logic            irq_n_q;

   // A new edge wins over a coincident clear so no event is lost.
   assign pend_d = (rise_pulse & rise_en) | (fall_pulse & fall_en) | (pend_q & ~irq_clr);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend_q  <= '0;
         irq_n_q <= 1'b1;
      end else begin
         pend_q  <= pend_d;
         irq_n_q <= ~|(pend_q & irq_mask);
      end
   end

   assign pending = pend_q;
   assign irq_n   = irq_n_q;

   // ---------------- reset stretch ----------------
   logic [SYNC_STAGES-1:0] rb_sync_q;
   logic                   rb;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   sysrst_q, sysrst_d;

   assign rb = rb_sync_q[SYNC_STAGES-1];

   always_comb begin
      hold_d   = hold_q;
      sysrst_d = sysrst_q;
      if (rb) begin
         hold_d   = '0;
         sysrst_d = 1'b0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d   = hold_q + HOLD_W'(1);
         sysrst_d = 1'b0;
      end else begin
         // Counter saturates here; release stays until the button is pressed.
         sysrst_d = 1'b1;
      end
   end

   // The button chain resets to "not pressed" so the stretch starts counting
   // right after resetn releases.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rb_sync_q <= '0;
         hold_q    <= '0;
         sysrst_q  <= 1'b0;
      end else begin
         rb_sync_q <= {rb_sync_q[SYNC_STAGES-2:0], rst_btn};
         hold_q    <= hold_d;
         sysrst_q  <= sysrst_d;
      end
   end

   assign sys_resetn = sysrst_q;

endmodule
